// File: rtl/controlador_estados.sv
`default_nettype none
// ============================================================================
// Module      : controlador_estados
// Description : Pet behaviour sequencer: buttons -> estado code, with
//               attribute-based arbitration, refusal of full attributes and
//               an absorbing dead state.
// Revision    : 1.0 - initial release
// ============================================================================
module controlador_estados #(
    parameter int         DURACAO      = 200,
    parameter logic [7:0] LIMITE_CHEIO = 8'd100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_dormir,
    input  logic       btn_comer,
    input  logic       btn_aula,
    input  logic [7:0] fome,
    input  logic [7:0] felicidade,
    input  logic [7:0] sono,
    input  logic       morreu,
    output logic [2:0] estado,
    output logic       ocupado,
    output logic       rejeitado
);

    localparam int CW = (DURACAO > 1) ? $clog2(DURACAO) : 1;
    localparam logic [CW-1:0] c_ULTIMO = CW'(DURACAO - 1);

    localparam logic [2:0] c_PARADO     = 3'b000;
    localparam logic [2:0] c_DORMINDO   = 3'b001;
    localparam logic [2:0] c_COMENDO    = 3'b010;
    localparam logic [2:0] c_DANDO_AULA = 3'b011;
    localparam logic [2:0] c_MORTO      = 3'b100;

    logic [2:0]      r_estado, w_estado_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]      r_pend, w_pend_nxt;
    logic [2:0]      r_btn_q;
    logic            r_ocupado, w_ocupado_nxt;
    logic            r_rejeitado, w_rejeitado_nxt;

    logic [2:0]      w_btn, w_subida, w_limpa, w_bloqueio;
    logic [2:0][7:0] w_attr;
    logic [7:0]      w_attr_atual;
    logic            w_sel_valido;
    logic [1:0]      w_sel_idx;
    logic [7:0]      w_sel_val;

    // Bit i of every flag vector maps to action code i+1
    assign w_btn    = {btn_aula, btn_comer, btn_dormir};
    assign w_subida = w_btn & ~r_btn_q;
    assign w_attr   = {felicidade, fome, sono};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado    <= c_PARADO;
            r_cnt       <= '0;
            r_pend      <= 3'b000;
            r_btn_q     <= 3'b111;
            r_ocupado   <= 1'b0;
            r_rejeitado <= 1'b0;
        end else begin
            r_estado    <= w_estado_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pend      <= w_pend_nxt;
            r_btn_q     <= w_btn;
            r_ocupado   <= w_ocupado_nxt;
            r_rejeitado <= w_rejeitado_nxt;
        end
    end

    // Lowest attribute wins; strict compare keeps earlier index on ties
    always_comb begin
        w_sel_valido = 1'b0;
        w_sel_idx    = 2'd0;
        w_sel_val    = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            if (r_pend[i] && (!w_sel_valido || (w_attr[i] < w_sel_val))) begin
                w_sel_valido = 1'b1;
                w_sel_idx    = 2'(i);
                w_sel_val    = w_attr[i];
            end
        end
    end

    always_comb begin
        w_estado_nxt    = r_estado;
        w_cnt_nxt       = r_cnt;
        w_limpa         = 3'b000;
        w_bloqueio      = 3'b000;
        w_rejeitado_nxt = 1'b0;
        w_attr_atual    = 8'd0;
        case (r_estado)
            c_PARADO: begin
                if (w_sel_valido) begin
                    w_limpa = 3'b001 << w_sel_idx;
                    if (w_sel_val >= LIMITE_CHEIO) begin
                        w_rejeitado_nxt = 1'b1;
                    end else begin
                        w_estado_nxt = {1'b0, w_sel_idx + 2'd1};
                        w_cnt_nxt    = '0;
                    end
                end
            end
            c_DORMINDO, c_COMENDO, c_DANDO_AULA: begin
                w_bloqueio   = 3'b001 << (r_estado[1:0] - 2'd1);
                w_attr_atual = w_attr[r_estado[1:0] - 2'd1];
                if ((r_cnt == c_ULTIMO) || (w_attr_atual >= LIMITE_CHEIO)) begin
                    w_estado_nxt = c_PARADO;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_MORTO: begin
                w_bloqueio = 3'b111;
            end
            default: begin
                w_estado_nxt = c_PARADO;
                w_cnt_nxt    = '0;
            end
        endcase
        w_pend_nxt = (r_pend & ~w_limpa) | (w_subida & ~w_bloqueio);
        if (morreu) begin
            w_estado_nxt    = c_MORTO;
            w_cnt_nxt       = '0;
            w_pend_nxt      = 3'b000;
            w_rejeitado_nxt = 1'b0;
        end
    end

    always_comb begin
        w_ocupado_nxt = (w_estado_nxt == c_DORMINDO) || (w_estado_nxt == c_COMENDO) ||
                        (w_estado_nxt == c_DANDO_AULA);
        estado        = r_estado;
        ocupado       = r_ocupado;
        rejeitado     = r_rejeitado;
    end

endmodule
`default_nettype wire

// File: tb/tb_controlador_estados.sv
`default_nettype none
// ============================================================================
// Module      : tb_controlador_estados
// Description : Directed self-checking bench for controlador_estados.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_estados;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_dormir = 1'b0, btn_comer = 1'b0, btn_aula = 1'b0;
    logic [7:0] fome = 8'd50, felicidade = 8'd50, sono = 8'd50;
    logic       morreu = 1'b0;
    logic [2:0] estado;
    logic       ocupado, rejeitado;

    int n_checks = 0;
    int n_errors = 0;

    controlador_estados #(.DURACAO(200), .LIMITE_CHEIO(8'd100)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_dormir(btn_dormir), .btn_comer(btn_comer), .btn_aula(btn_aula),
        .fome(fome), .felicidade(felicidade), .sono(sono),
        .morreu(morreu),
        .estado(estado), .ocupado(ocupado), .rejeitado(rejeitado)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        tick(2);
        n_checks++;
        if (estado !== 3'b000 || ocupado !== 1'b0 || rejeitado !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_values: estado=%b ocupado=%b rejeitado=%b expected 000/0/0", estado, ocupado, rejeitado);
        end
        rst_n = 1'b1;
        tick(2);
        n_checks++;
        if (estado !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_idle: estado=%b expected 000", estado);
        end
    endtask

    task automatic test_comer;
        fome = 8'd50;
        btn_comer = 1'b1;
        tick();
        btn_comer = 1'b0;
        n_checks++;
        if (estado !== 3'b000) begin
            n_errors++;
            $display("FAIL comer_pending: estado=%b expected 000", estado);
        end
        tick();
        n_checks++;
        if (estado !== 3'b010 || ocupado !== 1'b1) begin
            n_errors++;
            $display("FAIL comer_grant: estado=%b ocupado=%b expected 010/1", estado, ocupado);
        end
        tick(199);
        n_checks++;
        if (estado !== 3'b010) begin
            n_errors++;
            $display("FAIL comer_last_cycle: estado=%b expected 010", estado);
        end
        tick();
        n_checks++;
        if (estado !== 3'b000 || ocupado !== 1'b0) begin
            n_errors++;
            $display("FAIL comer_end: estado=%b ocupado=%b expected 000/0", estado, ocupado);
        end
    endtask

    task automatic test_back_to_back;
        sono = 8'd40; felicidade = 8'd30; fome = 8'd50;
        btn_dormir = 1'b1; btn_aula = 1'b1;
        tick();
        btn_dormir = 1'b0; btn_aula = 1'b0;
        tick();
        n_checks++;
        if (estado !== 3'b011) begin
            n_errors++;
            $display("FAIL arb_lowest_first: estado=%b expected 011", estado);
        end
        tick(199);
        n_checks++;
        if (estado !== 3'b011) begin
            n_errors++;
            $display("FAIL arb_aula_hold: estado=%b expected 011", estado);
        end
        tick();
        n_checks++;
        if (estado !== 3'b000) begin
            n_errors++;
            $display("FAIL b2b_gap: estado=%b expected 000", estado);
        end
        tick();
        n_checks++;
        if (estado !== 3'b001) begin
            n_errors++;
            $display("FAIL b2b_second: estado=%b expected 001", estado);
        end
        sono = 8'd100;
        tick();
        n_checks++;
        if (estado !== 3'b000) begin
            n_errors++;
            $display("FAIL b2b_exit: estado=%b expected 000", estado);
        end
        sono = 8'd50; felicidade = 8'd50;
    endtask

    task automatic test_tie;
        sono = 8'd60; fome = 8'd60;
        btn_dormir = 1'b1; btn_comer = 1'b1;
        tick();
        btn_dormir = 1'b0; btn_comer = 1'b0;
        tick();
        n_checks++;
        if (estado !== 3'b001) begin
            n_errors++;
            $display("FAIL tie_priority: estado=%b expected 001", estado);
        end
        sono = 8'd100;
        tick(2);
        n_checks++;
        if (estado !== 3'b010) begin
            n_errors++;
            $display("FAIL tie_second: estado=%b expected 010", estado);
        end
        fome = 8'd100;
        tick();
        n_checks++;
        if (estado !== 3'b000) begin
            n_errors++;
            $display("FAIL tie_exit: estado=%b expected 000", estado);
        end
        sono = 8'd50; fome = 8'd50;
    endtask

    task automatic test_reject;
        fome = 8'd100;
        btn_comer = 1'b1;
        tick();
        btn_comer = 1'b0;
        n_checks++;
        if (rejeitado !== 1'b0) begin
            n_errors++;
            $display("FAIL reject_early: rejeitado=%b expected 0", rejeitado);
        end
        tick();
        n_checks++;
        if (rejeitado !== 1'b1 || estado !== 3'b000) begin
            n_errors++;
            $display("FAIL reject_pulse: rejeitado=%b estado=%b expected 1/000", rejeitado, estado);
        end
        tick();
        n_checks++;
        if (rejeitado !== 1'b0 || estado !== 3'b000) begin
            n_errors++;
            $display("FAIL reject_single: rejeitado=%b estado=%b expected 0/000", rejeitado, estado);
        end
        fome = 8'd50;
    endtask

    task automatic test_early_exit;
        sono = 8'd95;
        btn_dormir = 1'b1;
        tick();
        btn_dormir = 1'b0;
        tick();
        n_checks++;
        if (estado !== 3'b001) begin
            n_errors++;
            $display("FAIL early_grant: estado=%b expected 001", estado);
        end
        for (int v = 96; v < 100; v++) begin
            sono = 8'(v);
            tick();
            n_checks++;
            if (estado !== 3'b001) begin
                n_errors++;
                $display("FAIL early_ramp_%0d: estado=%b expected 001", v, estado);
            end
        end
        sono = 8'd100;
        tick();
        n_checks++;
        if (estado !== 3'b000) begin
            n_errors++;
            $display("FAIL early_exit: estado=%b expected 000", estado);
        end
        sono = 8'd50;
    endtask

    task automatic test_morreu;
        fome = 8'd50;
        btn_comer = 1'b1;
        tick();
        btn_comer = 1'b0;
        tick();
        btn_aula = 1'b1;
        tick();
        btn_aula = 1'b0;
        n_checks++;
        if (estado !== 3'b010) begin
            n_errors++;
            $display("FAIL death_pre: estado=%b expected 010", estado);
        end
        morreu = 1'b1;
        tick();
        n_checks++;
        if (estado !== 3'b100 || ocupado !== 1'b0) begin
            n_errors++;
            $display("FAIL death_enter: estado=%b ocupado=%b expected 100/0", estado, ocupado);
        end
        morreu = 1'b0;
        btn_comer = 1'b1;
        tick();
        btn_comer = 1'b0;
        tick(3);
        n_checks++;
        if (estado !== 3'b100) begin
            n_errors++;
            $display("FAIL death_absorb: estado=%b expected 100", estado);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (estado !== 3'b000 || ocupado !== 1'b0) begin
            n_errors++;
            $display("FAIL death_async_reset: estado=%b ocupado=%b expected 000/0", estado, ocupado);
        end
        tick();
        rst_n = 1'b1;
        tick(3);
        n_checks++;
        if (estado !== 3'b000) begin
            n_errors++;
            $display("FAIL death_flags_cleared: estado=%b expected 000", estado);
        end
    endtask

    task automatic test_hold_through_reset;
        sono = 8'd40;
        btn_dormir = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(3);
        n_checks++;
        if (estado !== 3'b000 || ocupado !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_no_request: estado=%b ocupado=%b expected 000/0", estado, ocupado);
        end
        btn_dormir = 1'b0;
        tick();
        btn_dormir = 1'b1;
        tick(2);
        btn_dormir = 1'b0;
        n_checks++;
        if (estado !== 3'b001) begin
            n_errors++;
            $display("FAIL hold_repress: estado=%b expected 001", estado);
        end
        sono = 8'd50;
    endtask

    initial begin
        test_reset();
        test_comer();
        test_back_to_back();
        test_tie();
        test_reject();
        test_early_exit();
        test_morreu();
        test_hold_through_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
